// File: rtl/d5m_pattern_source.sv
// D5M sensor emulator: drives 12-bit raw test patterns with sensor-identical FVAL/LVAL framing.
// Every output is registered from the next-state values, so framing edges line up with state changes.
module d5m_pattern_source #(
  parameter int unsigned H_ACTIVE = 1280,
  parameter int unsigned V_ACTIVE = 960,
  parameter int unsigned H_BLANK  = 40,
  parameter int unsigned FV_LEAD  = 8,
  parameter int unsigned F_TAIL   = 8,
  parameter int unsigned V_BLANK  = 100
) (
  input  logic        D5M_PIXCLK,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        single_shot,
  input  logic [1:0]  pattern_sel,
  input  logic [11:0] solid_value,
  output logic [11:0] D5M_D,
  output logic        D5M_FVAL,
  output logic        D5M_LVAL,
  output logic        frame_done,
  output logic [15:0] frame_cnt,
  output logic        busy
);

  localparam int unsigned MAX_HA = (H_ACTIVE > H_BLANK) ? H_ACTIVE : H_BLANK;
  localparam int unsigned MAX_LT = (FV_LEAD > F_TAIL) ? FV_LEAD : F_TAIL;
  localparam int unsigned MAX_AB = (MAX_HA > MAX_LT) ? MAX_HA : MAX_LT;
  localparam int unsigned MAX_LEN = (MAX_AB > V_BLANK) ? MAX_AB : V_BLANK;
  localparam int unsigned CNT_W = $clog2(MAX_LEN + 1);
  localparam int unsigned Y_W = $clog2(V_ACTIVE + 1);
  localparam int unsigned PIX_W = 12;
  localparam int unsigned FCNT_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    LEAD,
    LINE,
    HBLANK,
    TAIL,
    VBLANK
  } state_t;

  state_t              state_q, state_n;
  logic [CNT_W-1:0]    cnt_q, cnt_n;
  logic [Y_W-1:0]      y_q, y_n;
  logic [1:0]          pat_q, pat_n;
  logic [PIX_W-1:0]    sv_q, sv_n;
  logic                oneshot_q, oneshot_n;
  logic [FCNT_W-1:0]   frame_cnt_q, fcnt_n;
  logic                done_n;
  logic [PIX_W-1:0]    x12, y12, pix, d_n;

  // Next-state and counter logic; cnt doubles as the active x coordinate in LINE.
  always_comb begin
    state_n   = state_q;
    cnt_n     = cnt_q;
    y_n       = y_q;
    pat_n     = pat_q;
    sv_n      = sv_q;
    oneshot_n = oneshot_q;
    fcnt_n    = frame_cnt_q;
    done_n    = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable | single_shot) begin
          state_n   = LEAD;
          cnt_n     = '0;
          y_n       = '0;
          pat_n     = pattern_sel;
          sv_n      = solid_value;
          oneshot_n = ~enable;
        end
      end
      LEAD: begin
        if (cnt_q == CNT_W'(FV_LEAD - 1)) begin
          state_n = LINE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end
      LINE: begin
        if (cnt_q == CNT_W'(H_ACTIVE - 1)) begin
          cnt_n   = '0;
          state_n = (y_q == Y_W'(V_ACTIVE - 1)) ? TAIL : HBLANK;
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end
      HBLANK: begin
        if (cnt_q == CNT_W'(H_BLANK - 1)) begin
          state_n = LINE;
          cnt_n   = '0;
          y_n     = y_q + Y_W'(1);
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end
      TAIL: begin
        if (cnt_q == CNT_W'(F_TAIL - 1)) begin
          state_n = VBLANK;
          cnt_n   = '0;
          done_n  = 1'b1;
          fcnt_n  = frame_cnt_q + FCNT_W'(1);
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end
      VBLANK: begin
        if (cnt_q == CNT_W'(V_BLANK - 1)) begin
          cnt_n = '0;
          if (enable && !oneshot_q) begin
            state_n = LEAD;
            y_n     = '0;
            pat_n   = pattern_sel;
            sv_n    = solid_value;
          end else begin
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Pattern generator on the coordinates the outputs will present after the next edge.
  always_comb begin
    x12 = PIX_W'(cnt_n);
    y12 = PIX_W'(y_n);
    case (pat_q)
      2'd0:    pix = sv_q;
      2'd1:    pix = {x12[9:0], 2'b00};
      2'd2:    pix = (x12[5] ^ y12[5]) ? 12'hFFF : 12'h000;
      default: pix = x12 + y12 + {4'h0, frame_cnt_q[7:0]};
    endcase
    d_n = (state_n == LINE) ? pix : '0;
  end

  // State and control registers.
  always_ff @(posedge D5M_PIXCLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      y_q         <= '0;
      pat_q       <= '0;
      sv_q        <= '0;
      oneshot_q   <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_n;
      cnt_q       <= cnt_n;
      y_q         <= y_n;
      pat_q       <= pat_n;
      sv_q        <= sv_n;
      oneshot_q   <= oneshot_n;
      frame_cnt_q <= fcnt_n;
    end
  end

  // Output registers.
  always_ff @(posedge D5M_PIXCLK or negedge rst_n) begin
    if (!rst_n) begin
      D5M_D      <= '0;
      D5M_FVAL   <= 1'b0;
      D5M_LVAL   <= 1'b0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      D5M_D      <= d_n;
      D5M_FVAL   <= (state_n == LEAD) || (state_n == LINE) ||
                    (state_n == HBLANK) || (state_n == TAIL);
      D5M_LVAL   <= (state_n == LINE);
      frame_done <= done_n;
      busy       <= (state_n != IDLE);
    end
  end

  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_d5m_pattern_source.sv
// Bench for d5m_pattern_source: frame-position reference model checked every cycle, plus directed scenarios.
module tb_d5m_pattern_source;

  localparam int H = 8, V = 4, HB = 3, FL = 2, FT = 2, VB = 5;
  localparam int ACT = V * H + (V - 1) * HB;
  localparam int FV_LEN = FL + ACT + FT;
  localparam int PERIOD = FV_LEN + VB;

  logic clk = 1'b0, rst_n = 1'b0, enable = 1'b0, single_shot = 1'b0;
  logic [1:0] pattern_sel = 2'd0;
  logic [11:0] solid_value = 12'd0;
  logic [11:0] D5M_D;
  logic D5M_FVAL, D5M_LVAL, frame_done, busy;
  logic [15:0] frame_cnt;

  d5m_pattern_source #(
    .H_ACTIVE(H), .V_ACTIVE(V), .H_BLANK(HB), .FV_LEAD(FL), .F_TAIL(FT), .V_BLANK(VB)
  ) dut (
    .D5M_PIXCLK(clk), .rst_n(rst_n), .enable(enable), .single_shot(single_shot),
    .pattern_sel(pattern_sel), .solid_value(solid_value), .D5M_D(D5M_D),
    .D5M_FVAL(D5M_FVAL), .D5M_LVAL(D5M_LVAL), .frame_done(frame_done),
    .frame_cnt(frame_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pat(int p, int sv, int x, int y, int fc);
    case (p)
      0: return sv;
      1: return (x * 4) % 4096;
      2: return (((x / 32) + (y / 32)) % 2 == 1) ? 4095 : 0;
      default: return (x + y + (fc % 256)) % 4096;
    endcase
  endfunction

  // Reference model: a frame is a run of PERIOD cycles indexed by m_t.
  bit m_run = 0, m_one = 0;
  int m_t = 0, m_pat = 0, m_sv = 0, m_fcnt = 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run = 0; m_t = 0; m_fcnt = 0;
    end else if (!m_run) begin
      if (enable || single_shot) begin
        m_run = 1; m_t = 0; m_pat = int'(pattern_sel); m_sv = int'(solid_value);
        m_one = !enable;
      end
    end else begin
      m_t++;
      if (m_t == FV_LEN) m_fcnt = (m_fcnt + 1) % 65536;
      if (m_t == PERIOD) begin
        if (enable && !m_one) begin
          m_t = 0; m_pat = int'(pattern_sel); m_sv = int'(solid_value);
        end else begin
          m_run = 0; m_t = 0;
        end
      end
    end
  end

  always @(negedge clk) begin : cmp
    int u, ln, pos, ed;
    bit ef, el, edn;
    ef = m_run && (m_t < FV_LEN);
    edn = m_run && (m_t == FV_LEN);
    el = 0; ed = 0;
    u = m_t - FL;
    if (m_run && u >= 0 && u < ACT) begin
      ln = u / (H + HB);
      pos = u % (H + HB);
      if (pos < H) begin
        el = 1;
        ed = pat(m_pat, m_sv, pos, ln, m_fcnt);
      end
    end
    chk("fval", 32'(D5M_FVAL), 32'(ef));
    chk("lval", 32'(D5M_LVAL), 32'(el));
    chk("data", 32'(D5M_D), ed);
    chk("frame_done", 32'(frame_done), 32'(edn));
    chk("frame_cnt", 32'(frame_cnt), m_fcnt);
    chk("busy", 32'(busy), 32'(m_run));
  end

  // Passive framing monitor used by the directed checks.
  int frames_started, fv_cur, fv_last, low_cur, low_last, line, x, bursts;
  int done_cnt, vb_cur, vb_last;
  int done_fcnt[8], probe[8], line0[8];
  bit p_fval, p_lval, p_busy;
  always @(negedge clk) begin
    if (!rst_n) begin
      frames_started = 0; fv_cur = 0; fv_last = 0; low_cur = 0; low_last = 0;
      line = -1; x = 0; bursts = 0; done_cnt = 0; vb_cur = 0; vb_last = 0;
      p_fval = 0; p_lval = 0; p_busy = 0;
      for (int i = 0; i < 8; i++) begin done_fcnt[i] = -1; probe[i] = -1; line0[i] = -1; end
    end else begin
      if (D5M_FVAL && !p_fval) begin
        frames_started++; fv_cur = 0; line = -1;
        if (frames_started > 1) low_last = low_cur;
      end
      if (D5M_FVAL) fv_cur++;
      else begin
        if (p_fval) begin fv_last = fv_cur; low_cur = 0; end
        low_cur++;
      end
      if (D5M_LVAL && !p_lval) begin line++; x = 0; bursts++; end
      if (D5M_LVAL) begin
        if (frames_started > 0 && frames_started <= 8) begin
          if (line == 1 && x == 2) probe[frames_started-1] = int'(D5M_D);
          if (frames_started == 1 && line == 0 && x < 8) line0[x] = int'(D5M_D);
        end
        x++;
      end
      if (frame_done) begin
        if (done_cnt < 8) done_fcnt[done_cnt] = int'(frame_cnt);
        done_cnt++;
      end
      if (busy && !D5M_FVAL) vb_cur++;
      else begin
        if (p_busy && !busy) vb_last = vb_cur;
        vb_cur = 0;
      end
      p_fval = D5M_FVAL; p_lval = D5M_LVAL; p_busy = busy;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; enable = 1'b0; single_shot = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic wait_done(input int n, input int bud, input string name);
    for (int i = 0; i < bud && done_cnt < n; i++) tick();
    chk(name, 32'(done_cnt >= n), 32'd1);
  endtask

  task automatic wait_idle(input int bud, input string name);
    for (int i = 0; i < bud && busy; i++) tick();
    chk(name, 32'(busy), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    repeat (3) tick();
    chk("rst_fval", 32'(D5M_FVAL), 32'd0);
    chk("rst_lval", 32'(D5M_LVAL), 32'd0);
    chk("rst_data", 32'(D5M_D), 32'd0);
    chk("rst_fcnt", 32'(frame_cnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    tick();

    // Single shot, solid 0xABC; a second pulse mid-frame must be ignored.
    pattern_sel = 2'd0; solid_value = 12'hABC; single_shot = 1'b1;
    tick();
    single_shot = 1'b0;
    repeat (10) tick();
    single_shot = 1'b1;
    tick();
    single_shot = 1'b0;
    wait_done(1, 200, "t1_done_timeout");
    wait_idle(50, "t1_idle_timeout");
    chk("t1_fval_len", fv_last, 45);
    chk("t1_bursts", bursts, 4);
    chk("t1_done_cnt", done_cnt, 1);
    chk("t1_frame_cnt", 32'(frame_cnt), 32'd1);
    chk("t1_vblank_to_idle", vb_last, 5);
    chk("t1_probe", probe[0], 32'hABC);
    repeat (20) tick();
    chk("t1_no_restart", frames_started, 1);

    // Free-run ramp: back-to-back frames.
    do_reset();
    pattern_sel = 2'd1; enable = 1'b1;
    wait_done(3, 400, "t2_done_timeout");
    chk("t2_fcnt0", done_fcnt[0], 1);
    chk("t2_fcnt1", done_fcnt[1], 2);
    chk("t2_fcnt2", done_fcnt[2], 3);
    chk("t2_fval_low", low_last, 5);
    chk("t2_no_idle", vb_last, 0);
    chk("t2_fval_len", fv_last, 45);
    for (int i = 0; i < 8; i++) chk($sformatf("t2_ramp%0d", i), line0[i], 4 * i);
    enable = 1'b0;
    wait_idle(100, "t2_idle_timeout");

    // Moving diagonal across two frames.
    do_reset();
    pattern_sel = 2'd3; enable = 1'b1;
    wait_done(2, 300, "t3_done_timeout");
    enable = 1'b0;
    chk("t3_frame0", probe[0], 3);
    chk("t3_frame1", probe[1], 4);
    wait_idle(100, "t3_idle_timeout");

    // Mid-frame pattern change and enable drop.
    do_reset();
    pattern_sel = 2'd0; solid_value = 12'h123; enable = 1'b1;
    for (int i = 0; i < 100 && bursts < 2; i++) tick();
    chk("t4_line1_timeout", 32'(bursts >= 2), 32'd1);
    pattern_sel = 2'd2; solid_value = 12'h000; enable = 1'b0;
    wait_idle(200, "t4_idle_timeout");
    chk("t4_done_cnt", done_cnt, 1);
    chk("t4_bursts", bursts, 4);
    chk("t4_fval_len", fv_last, 45);
    chk("t4_probe", probe[0], 32'h123);
    repeat (30) tick();
    chk("t4_no_restart", frames_started, 1);
    chk("t4_fval_low", 32'(D5M_FVAL), 32'd0);

    // Reset during frame 2 at line 2, x 5.
    do_reset();
    pattern_sel = 2'd1; enable = 1'b1;
    for (int i = 0; i < 200 && frames_started < 2; i++) tick();
    chk("t5_frame2_timeout", frames_started, 2);
    repeat (29) tick();
    chk("t5_pre_lval", 32'(D5M_LVAL), 32'd1);
    chk("t5_pre_data", 32'(D5M_D), 32'd20);
    chk("t5_pre_fcnt", 32'(frame_cnt), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_fval", 32'(D5M_FVAL), 32'd0);
    chk("t5_rst_lval", 32'(D5M_LVAL), 32'd0);
    chk("t5_rst_data", 32'(D5M_D), 32'd0);
    chk("t5_rst_fcnt", 32'(frame_cnt), 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    wait_done(1, 200, "t5_done_timeout");
    chk("t5_fval_len", fv_last, 45);
    chk("t5_bursts", bursts, 4);
    chk("t5_fcnt", 32'(frame_cnt), 32'd1);
    enable = 1'b0;
    wait_idle(100, "t5_idle_timeout");

    // Frame counter wrap from 0xFFFF.
    do_reset();
    force dut.frame_cnt_q = 16'hFFFF;
    m_fcnt = 65535;
    #1;
    release dut.frame_cnt_q;
    pattern_sel = 2'd3; single_shot = 1'b1;
    tick();
    single_shot = 1'b0;
    wait_done(1, 200, "t6_done_timeout");
    chk("t6_wrap_done", done_fcnt[0], 0);
    wait_idle(50, "t6_idle_timeout");
    chk("t6_wrap", 32'(frame_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
